// File: rtl/word_serial_adder_if.sv
// Operand/result handshake bundle for word_serial_adder.
// master drives operands and result acceptance; slave is the adder.
interface word_serial_adder_if #(
   parameter int N     = 8,
   parameter int WORDS = 4
);
   localparam int W = N * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/word_serial_adder.sv
// Wide adder built from one N-bit ripple slice reused over WORDS clocks,
// LSB slice first, with the inter-slice carry held in a register.
module ripple_carry_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] st,
   output logic         cout
);
   always_comb begin
      logic carry;
      carry = cin;
      st    = '0;
      for (int i = 0; i < N; i++) begin
         st[i] = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end
      cout = carry;
   end
endmodule

// state | meaning
// IDLE  | ready for an operand set
// RUN   | adding slice idx_q; last slice moves to DONE
// DONE  | result held until out_ready
module word_serial_adder #(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input logic                clk,
   input logic                rst,
   word_serial_adder_if.slave bus
);
   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, b_q, sum_q;
   logic [IW-1:0] idx_q;
   logic          carry_q, cout_q, out_valid_q;
   logic [N-1:0]  a_sl, b_sl, st;
   logic          co;

   assign a_sl = a_q[int'(idx_q)*N +: N];
   assign b_sl = b_q[int'(idx_q)*N +: N];

   ripple_carry_adder #(.N(N)) u_rca (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .st   (st),
      .cout (co)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = RUN;
         RUN:     if (idx_q == LAST) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  idx_q   <= '0;
                  sum_q   <= '0;
               end
            end
            RUN: begin
               sum_q[int'(idx_q)*N +: N] <= st;
               carry_q                   <= co;
               if (idx_q == LAST) begin
                  cout_q      <= co;
                  out_valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // in_ready depends only on state and rst, never on in_valid
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.busy      = (state_q != IDLE);
endmodule
